mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Bridges CPU load/store requests onto a little-endian 32-bit word bus
//   (Avalon-MM style). It checks alignment, steers the byte lanes and
//   store data, holds the CPU stalled while a bus cycle is in flight, and
//   formats the returned word for byte/half/word/LWL/LWR loads.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   req_read, req_write            load / store request from decode
//   req_byte_enable                size code: 0001 byte, 0011 half, 1111 word
//   req_sign                       sign-extend byte/half loads
//   req_lwlr                       1x = partial-word load (11 LWL, 10 LWR)
//   req_addr, req_wdata            byte address, store data
//   req_rt_old                     current rt, merged into LWL/LWR results
//   stall                          CPU holds PC and request while high
//   rdata, rdata_valid             formatted load result, one-cycle valid
//   err_align                      one-cycle pulse on an illegal request
//   avm_*                          bus master side

module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [3:0]  req_byte_enable,
    input  logic        req_sign,
    input  logic [1:0]  req_lwlr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err_align,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;

    logic [31:0] addr_q,   addr_d;
    logic        rd_q,     rd_d;
    logic        wr_q,     wr_d;
    logic [3:0]  be_q,     be_d;
    logic [31:0] wd_q,     wd_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q,    err_d;
    logic [31:0] rdata_q,  rdata_d;

    // Request context kept for formatting the returned word.
    logic [1:0]  k_q,      k_d;
    logic        byte_q,   byte_d;
    logic        half_q,   half_d;
    logic        sign_q,   sign_d;
    logic [1:0]  lwlr_q,   lwlr_d;
    logic [31:0] rt_q,     rt_d;

    logic [1:0]  k;
    logic        is_lwlr, is_byte, is_half, aligned, accept, reject;
    logic [31:0] load_fmt;

    // Request decode and alignment check.
    always_comb begin
        k       = req_addr[1:0];
        is_lwlr = req_lwlr[1];
        is_byte = !is_lwlr && (req_byte_enable == 4'b0001);
        is_half = !is_lwlr && (req_byte_enable == 4'b0011);
        if (is_lwlr || is_byte)
            aligned = 1'b1;
        else if (is_half)
            aligned = !k[0];
        else
            aligned = (k == 2'b00);
        accept = (state_q == IDLE) && (req_read ^ req_write) && aligned;
        reject = (state_q == IDLE) && (req_read || req_write) && !accept;
    end

    // Load formatting from the word on the bus at the completing edge.
    // For LWL the shift 8*(3-k) equals {~k,3'b000} on a 2-bit k.
    always_comb begin
        logic [31:0] sh;
        sh       = avm_readdata >> {k_q, 3'b000};
        load_fmt = avm_readdata;
        if (lwlr_q == 2'b11)
            load_fmt = (avm_readdata << {~k_q, 3'b000})
                     | (rt_q & ~(32'hFFFF_FFFF << {~k_q, 3'b000}));
        else if (lwlr_q == 2'b10)
            load_fmt = (avm_readdata >> {k_q, 3'b000})
                     | (rt_q & ~(32'hFFFF_FFFF >> {k_q, 3'b000}));
        else if (byte_q)
            load_fmt = {{24{sign_q & sh[7]}}, sh[7:0]};
        else if (half_q)
            load_fmt = {{16{sign_q & sh[15]}}, sh[15:0]};
    end

    // Next state and next register values.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wd_d     = wd_q;
        k_d      = k_q;
        byte_d   = byte_q;
        half_d   = half_q;
        sign_d   = sign_q;
        lwlr_d   = lwlr_q;
        rt_d     = rt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = reject;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = req_read ? READ : WRITE;
                    addr_d  = {req_addr[31:2], 2'b00};
                    be_d    = is_lwlr ? 4'b1111
                            : (is_byte || is_half) ? 4'(req_byte_enable << k)
                            : 4'b1111;
                    if (is_byte)
                        wd_d = {4{req_wdata[7:0]}};
                    else if (is_half)
                        wd_d = {2{req_wdata[15:0]}};
                    else
                        wd_d = req_wdata;
                    k_d     = k;
                    byte_d  = is_byte;
                    half_d  = is_half;
                    sign_d  = req_sign;
                    lwlr_d  = req_lwlr;
                    rt_d    = req_rt_old;
                end
            end
            READ: begin
                if (!avm_waitrequest) begin
                    state_d  = DONE;
                    rvalid_d = 1'b1;
                    rdata_d  = load_fmt;
                end
            end
            WRITE: begin
                if (!avm_waitrequest)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Bus strobes are registered copies of the state being entered.
        rd_d = (state_d == READ);
        wr_d = (state_d == WRITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            wd_q     <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            k_q      <= '0;
            byte_q   <= 1'b0;
            half_q   <= 1'b0;
            sign_q   <= 1'b0;
            lwlr_q   <= '0;
            rt_q     <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            be_q     <= be_d;
            wd_q     <= wd_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            k_q      <= k_d;
            byte_q   <= byte_d;
            half_q   <= half_d;
            sign_q   <= sign_d;
            lwlr_q   <= lwlr_d;
            rt_q     <= rt_d;
        end
    end

    // stall is combinational in IDLE so the CPU freezes in the accept cycle.
    assign stall          = !reset && (accept || state_q == READ || state_q == WRITE);
    assign rdata          = rdata_q;
    assign rdata_valid    = rvalid_q;
    assign err_align      = err_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read, req_write, req_sign;
    logic [3:0]  req_byte_enable;
    logic [1:0]  req_lwlr;
    logic [31:0] req_addr, req_wdata, req_rt_old;
    logic        stall, rdata_valid, err_align;
    logic [31:0] rdata;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_byte_enable(req_byte_enable), .req_sign(req_sign),
        .req_lwlr(req_lwlr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .err_align(err_align),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Expected outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic        e_stall, e_rd, e_wr, e_rv, e_err;
    logic [31:0] e_rdata, e_addr, e_wd;
    logic [3:0]  e_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",       32'(stall),       32'(e_stall));
            chk("avm_read",    32'(avm_read),    32'(e_rd));
            chk("avm_write",   32'(avm_write),   32'(e_wr));
            chk("rdata_valid", 32'(rdata_valid), 32'(e_rv));
            chk("err_align",   32'(err_align),   32'(e_err));
            chk("rdata",       rdata,            e_rdata);
            if (e_rd || e_wr) begin
                chk("avm_address",    avm_address,           e_addr);
                chk("avm_byteenable", 32'(avm_byteenable),   32'(e_be));
            end
            if (e_wr) chk("avm_writedata", avm_writedata, e_wd);
        end
    end

    // ---------------- behavioural model (byte-lane view) ----------------
    function automatic int size_of(input logic [3:0] be);
        if (be == 4'b0001) return 1;
        if (be == 4'b0011) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input logic [3:0] be, input logic [1:0] lw, input logic [31:0] a);
        int n = size_of(be);
        if (lw[1]) return 1'b1;
        return (int'(a[1:0]) % n) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] be, input logic [1:0] lw, input logic [31:0] a);
        logic [3:0] r = '0;
        int k = int'(a[1:0]);
        int n = size_of(be);
        if (lw[1]) return 4'b1111;
        for (int i = 0; i < 4; i++) if (i >= k && i < k + n) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wd(input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] r;
        int n = size_of(be);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] be, input logic sgn, input logic [1:0] lw,
                                           input logic [31:0] a, input logic [31:0] w, input logic [31:0] rt);
        logic [7:0] wb[4], rb[4], ob[4];
        logic [31:0] r;
        int k = int'(a[1:0]);
        int n = size_of(be);
        for (int i = 0; i < 4; i++) begin wb[i] = w[8*i +: 8]; rb[i] = rt[8*i +: 8]; end
        for (int i = 0; i < 4; i++) begin
            if (lw == 2'b11)      ob[i] = (i >= 3 - k) ? wb[i - (3 - k)] : rb[i];
            else if (lw == 2'b10) ob[i] = (i + k <= 3) ? wb[i + k] : rb[i];
            else if (i < n)       ob[i] = wb[i + k];
            else                  ob[i] = (sgn && wb[k + n - 1][7]) ? 8'hFF : 8'h00;
        end
        for (int i = 0; i < 4; i++) r[8*i +: 8] = ob[i];
        return r;
    endfunction

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_rv = 1'b0; e_err = 1'b0;
    endtask

    task automatic drop_req();
        req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [3:0] be, input logic sgn,
                      input logic [1:0] lw, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rt, input logic [31:0] word, input int unsigned nwait);
        bit legal = (rd ^ wr) && m_legal(be, lw, a);
        step();
        req_read = rd; req_write = wr; req_byte_enable = be; req_sign = sgn;
        req_lwlr = lw; req_addr = a; req_wdata = wd; req_rt_old = rt;
        avm_waitrequest = 1'b0; avm_readdata = 32'hDEAD_BEEF;
        idle_exp();
        e_stall = legal;
        if (!legal) begin
            step();
            drop_req();
            idle_exp();
            e_err = 1'b1;
            return;
        end
        for (int unsigned w = 0; w <= nwait; w++) begin
            step();
            avm_waitrequest = (w < nwait);
            avm_readdata    = (w < nwait) ? 32'hDEAD_BEEF : word;
            idle_exp();
            e_stall = 1'b1; e_rd = rd; e_wr = wr;
            e_addr  = {a[31:2], 2'b00};
            e_be    = m_be(be, lw, a);
            e_wd    = m_wd(be, wd);
        end
        step();  // DONE: request still held and must be ignored
        avm_waitrequest = 1'b1; avm_readdata = 32'hDEAD_BEEF;
        idle_exp();
        e_rv = rd;
        if (rd) e_rdata = m_load(be, sgn, lw, a, word, rt);
    endtask

    task automatic idle_cycle();
        step();
        drop_req();
        avm_waitrequest = 1'b0;
        idle_exp();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drop_req();
        req_byte_enable = 4'b1111; req_sign = 1'b0; req_lwlr = 2'b00;
        req_addr = '0; req_wdata = '0; req_rt_old = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0;
        #13;
        chk("rst_stall",  32'(stall), 32'd0);
        chk("rst_read",   32'(avm_read), 32'd0);
        chk("rst_write",  32'(avm_write), 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("rst_err",    32'(err_align), 32'd0);
        chk("rst_rdata",  rdata, 32'd0);
        chk("rst_addr",   avm_address, 32'd0);
        chk("rst_be",     32'(avm_byteenable), 32'd0);
        chk("rst_wd",     avm_writedata, 32'd0);
        step();
        reset = 1'b0;
        e_rdata = '0;
        idle_exp();
        chk_en = 1'b1;

        // LW
        op(1, 0, 4'b1111, 0, 2'b00, 32'h100, 0, 0, 32'h1234_5678, 0);
        chk("pin_lw", rdata, 32'h1234_5678);
        // LB / LBU at lane 3
        op(1, 0, 4'b0001, 1, 2'b00, 32'h103, 0, 0, 32'h80FF_0000, 0);
        chk("pin_lb", rdata, 32'hFFFF_FF80);
        op(1, 0, 4'b0001, 0, 2'b00, 32'h103, 0, 0, 32'h80FF_0000, 0);
        chk("pin_lbu", rdata, 32'h0000_0080);
        // SH with three wait cycles
        op(0, 1, 4'b0011, 0, 2'b00, 32'h22, 32'h1234_ABCD, 0, 0, 3);
        // LWL / LWR
        op(1, 0, 4'b1111, 0, 2'b11, 32'h41, 0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        chk("pin_lwl", rdata, 32'h2211_CCDD);
        op(1, 0, 4'b1111, 0, 2'b10, 32'h41, 0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        chk("pin_lwr", rdata, 32'hAA44_3322);
        // illegal requests
        op(1, 0, 4'b1111, 0, 2'b00, 32'h102, 0, 0, 0, 0);
        op(1, 1, 4'b1111, 0, 2'b00, 32'h100, 0, 0, 0, 0);
        op(0, 1, 4'b0011, 0, 2'b00, 32'h21, 32'h5555_AAAA, 0, 0, 0);
        idle_cycle();
        // more lanes and waits
        op(0, 1, 4'b0001, 0, 2'b00, 32'h201, 32'h0000_00A5, 0, 0, 0);
        op(1, 0, 4'b0011, 1, 2'b00, 32'h302, 0, 0, 32'h8001_7FFF, 1);
        chk("pin_lh", rdata, 32'hFFFF_8001);
        op(1, 0, 4'b0011, 0, 2'b00, 32'h300, 0, 0, 32'h8001_F00D, 0);
        op(0, 1, 4'b1111, 0, 2'b00, 32'h404, 32'hCAFE_F00D, 0, 0, 1);
        op(1, 0, 4'b1111, 0, 2'b11, 32'h40, 0, 32'h1122_3344, 32'hA1B2_C3D4, 2);
        op(1, 0, 4'b1111, 0, 2'b10, 32'h43, 0, 32'h1122_3344, 32'hA1B2_C3D4, 0);
        chk("pin_lwr3", rdata, 32'h1122_33A1);
        idle_cycle();

        // reset in the middle of a read with waitrequest held
        step();
        req_read = 1'b1; req_byte_enable = 4'b1111; req_lwlr = 2'b00; req_addr = 32'h500;
        avm_waitrequest = 1'b1;
        idle_exp(); e_stall = 1'b1;
        step();
        idle_exp(); e_stall = 1'b1; e_rd = 1'b1; e_addr = 32'h500; e_be = 4'b1111;
        step();
        chk_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_read",  32'(avm_read), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        drop_req();
        avm_waitrequest = 1'b0; avm_readdata = 32'h7777_7777;
        e_rdata = '0;
        idle_exp();
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        op(1, 0, 4'b1111, 0, 2'b00, 32'h600, 0, 0, 32'h0BAD_C0DE, 0);
        chk("pin_after_rst", rdata, 32'h0BAD_C0DE);
        idle_cycle();
        idle_cycle();
        step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
